mem_access_unit: RTL and testbench

//  MEM-stage consumer of the EX/MEM pipeline register outputs (me_*). Turns me_mem_read/
//  me_mem_write into a req/ack data-bus transaction, generating byte lanes and load sign/zero

---
 rtl/mem_access_unit.sv | 171 +++++++++++++++++
 tb/tb_mem_access_unit.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// MEM-stage data-bus access unit: turns EX/MEM load/store requests into a req/ack bus
// transaction with byte lanes, load extension, store-data forwarding and error reporting.
module mem_access_unit #(
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] me_alu_o,
  input  logic [31:0] me_regs_data2,
  input  logic [4:0]  me_rs2,
  input  logic        me_mem_read,
  input  logic        me_mem_write,
  input  logic [2:0]  me_func3_code,
  input  logic [4:0]  wb_rd,
  input  logic        wb_regs_write,
  input  logic [31:0] wb_data,
  output logic        dbus_req,
  output logic        dbus_we,
  output logic [31:0] dbus_addr,
  output logic [31:0] dbus_wdata,
  output logic [3:0]  dbus_be,
  input  logic        dbus_ack,
  input  logic [31:0] dbus_rdata,
  output logic        mem_stall,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        misalign_err,
  output logic        bus_timeout_err
);

  localparam int CW = $clog2(TIMEOUT_CYC);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t        state_reg;
  logic [CW-1:0] cnt_reg;
  logic [2:0]    func3_reg;
  logic [1:0]    off_reg;
  logic          is_read_reg;

  logic          access;
  logic          illegal;
  logic [1:0]    off;
  logic [1:0]    size;
  logic [31:0]   store_data;
  logic [3:0]    be_next;
  logic [31:0]   wdata_next;
  logic [31:0]   rdata_shifted;
  logic [31:0]   load_ext;

  assign access = me_mem_read | me_mem_write;
  assign off    = me_alu_o[1:0];
  assign size   = me_func3_code[1:0];

  // Forward a result still sitting in WB; x0 is never forwarded.
  assign store_data = (wb_regs_write && (wb_rd == me_rs2) && (wb_rd != 5'd0)) ? wb_data
                                                                              : me_regs_data2;

  always_comb begin
    illegal = 1'b1;
    unique case (me_func3_code)
      3'b000:  illegal = 1'b0;
      3'b001:  illegal = off[0];
      3'b010:  illegal = (off != 2'b00);
      3'b100:  illegal = me_mem_write;
      3'b101:  illegal = me_mem_write | off[0];
      default: illegal = 1'b1;
    endcase
  end

  always_comb begin
    be_next = 4'b1111;
    unique case (size)
      2'b00:   be_next = 4'b0001 << off;
      2'b01:   be_next = 4'b0011 << {off[1], 1'b0};
      default: be_next = 4'b1111;
    endcase
  end

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign wdata_next[8*gi +: 8] = (size == 2'b00) ? store_data[7:0] :
                                     (size == 2'b01) ? store_data[8*(gi%2) +: 8] :
                                                       store_data[8*gi +: 8];
    end
  endgenerate

  assign rdata_shifted = dbus_rdata >> {off_reg, 3'b000};

  always_comb begin
    load_ext = rdata_shifted;
    unique case (func3_reg)
      3'b000:  load_ext = {{24{rdata_shifted[7]}}, rdata_shifted[7:0]};
      3'b001:  load_ext = {{16{rdata_shifted[15]}}, rdata_shifted[15:0]};
      3'b100:  load_ext = {24'd0, rdata_shifted[7:0]};
      3'b101:  load_ext = {16'd0, rdata_shifted[15:0]};
      default: load_ext = rdata_shifted;
    endcase
  end

  assign mem_stall = (state_reg == BUSY) || ((state_reg == IDLE) && access);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg       <= IDLE;
      cnt_reg         <= '0;
      func3_reg       <= '0;
      off_reg         <= '0;
      is_read_reg     <= 1'b0;
      dbus_req        <= 1'b0;
      dbus_we         <= 1'b0;
      dbus_addr       <= '0;
      dbus_wdata      <= '0;
      dbus_be         <= '0;
      load_data       <= '0;
      load_valid      <= 1'b0;
      misalign_err    <= 1'b0;
      bus_timeout_err <= 1'b0;
    end else begin
      unique case (state_reg)
        IDLE: begin
          cnt_reg <= '0;
          if (access) begin
            is_read_reg <= ~me_mem_write;
            func3_reg   <= me_func3_code;
            off_reg     <= off;
            if (illegal) begin
              misalign_err <= 1'b1;
              load_valid   <= ~me_mem_write;
              load_data    <= '0;
              state_reg    <= DONE;
            end else begin
              dbus_req   <= 1'b1;
              dbus_we    <= me_mem_write;
              dbus_addr  <= {me_alu_o[31:2], 2'b00};
              dbus_be    <= be_next;
              dbus_wdata <= wdata_next;
              state_reg  <= BUSY;
            end
          end
        end
        BUSY: begin
          // An ack in the final counted cycle still completes the access normally.
          if (dbus_ack) begin
            dbus_req   <= 1'b0;
            load_valid <= is_read_reg;
            if (is_read_reg) load_data <= load_ext;
            state_reg  <= DONE;
          end else if (cnt_reg == CW'(TIMEOUT_CYC - 1)) begin
            dbus_req        <= 1'b0;
            load_data       <= '0;
            load_valid      <= is_read_reg;
            bus_timeout_err <= 1'b1;
            state_reg       <= DONE;
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end
        DONE: begin
          cnt_reg         <= '0;
          load_valid      <= 1'b0;
          misalign_err    <= 1'b0;
          bus_timeout_err <= 1'b0;
          state_reg       <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: loads, stores, forwarding, misalignment, timeout
// and asynchronous reset during a bus cycle.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] me_alu_o;
  logic [31:0] me_regs_data2;
  logic [4:0]  me_rs2;
  logic        me_mem_read;
  logic        me_mem_write;
  logic [2:0]  me_func3_code;
  logic [4:0]  wb_rd;
  logic        wb_regs_write;
  logic [31:0] wb_data;
  logic        dbus_req;
  logic        dbus_we;
  logic [31:0] dbus_addr;
  logic [31:0] dbus_wdata;
  logic [3:0]  dbus_be;
  logic        dbus_ack;
  logic [31:0] dbus_rdata;
  logic        mem_stall;
  logic [31:0] load_data;
  logic        load_valid;
  logic        misalign_err;
  logic        bus_timeout_err;

  mem_access_unit #(.TIMEOUT_CYC(16)) dut (
    .clk(clk), .rst(rst),
    .me_alu_o(me_alu_o), .me_regs_data2(me_regs_data2), .me_rs2(me_rs2),
    .me_mem_read(me_mem_read), .me_mem_write(me_mem_write), .me_func3_code(me_func3_code),
    .wb_rd(wb_rd), .wb_regs_write(wb_regs_write), .wb_data(wb_data),
    .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr), .dbus_wdata(dbus_wdata),
    .dbus_be(dbus_be), .dbus_ack(dbus_ack), .dbus_rdata(dbus_rdata),
    .mem_stall(mem_stall), .load_data(load_data), .load_valid(load_valid),
    .misalign_err(misalign_err), .bus_timeout_err(bus_timeout_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Per-transaction observations
  int          stall_cnt, busy_cyc;
  bit          unstable;
  logic [31:0] c_addr, c_wdata, d_ld;
  logic [3:0]  c_be;
  logic        c_we, d_lv, d_mis, d_to, d_req, post_lv, post_mis, post_to;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic issue(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] d2, input logic [4:0] rs2);
    @(posedge clk); #1;
    me_mem_read   = rd;
    me_mem_write  = wr;
    me_func3_code = f3;
    me_alu_o      = addr;
    me_regs_data2 = d2;
    me_rs2        = rs2;
  endtask

  // Acts as the bus slave (ack on the ack_after-th request cycle, 0 = never) and
  // records what the pipeline sees until the DONE cycle and one cycle after it.
  task automatic run_access(input string name, input int ack_after, input logic [31:0] rdata);
    bit done = 0;
    stall_cnt = 0; busy_cyc = 0; unstable = 0;
    c_addr = '0; c_wdata = '0; c_be = '0; c_we = 1'b0;
    d_ld = '0; d_lv = 1'b0; d_mis = 1'b0; d_to = 1'b0; d_req = 1'b0;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      #1;
      if (cyc > 0 && !mem_stall) begin
        done  = 1;
        d_ld  = load_data;
        d_lv  = load_valid;
        d_mis = misalign_err;
        d_to  = bus_timeout_err;
        d_req = dbus_req;
        me_mem_read  = 1'b0;
        me_mem_write = 1'b0;
      end else begin
        if (mem_stall) stall_cnt++;
        if (dbus_req) begin
          busy_cyc++;
          if (busy_cyc == 1) begin
            c_addr = dbus_addr; c_be = dbus_be; c_we = dbus_we; c_wdata = dbus_wdata;
          end else if (dbus_addr !== c_addr || dbus_be !== c_be || dbus_we !== c_we ||
                       dbus_wdata !== c_wdata) begin
            unstable = 1;
          end
          if (busy_cyc == ack_after) begin
            dbus_ack   = 1'b1;
            dbus_rdata = rdata;
          end
        end
      end
      @(posedge clk); #1;
      dbus_ack   = 1'b0;
      dbus_rdata = '0;
    end
    if (!done) begin
      check({name, "_done_reached"}, 32'd0, 32'd1);
      me_mem_read  = 1'b0;
      me_mem_write = 1'b0;
    end
    #1;
    post_lv  = load_valid;
    post_mis = misalign_err;
    post_to  = bus_timeout_err;
    check({name, "_no_restart"}, {31'd0, dbus_req}, 32'd0);
    check({name, "_done_req_low"}, {31'd0, d_req}, 32'd0);
    check({name, "_stable"}, {31'd0, unstable}, 32'd0);
    $display("txn %s: stall=%0d busy=%0d addr=0x%08h be=%b we=%0d wdata=0x%08h load=0x%08h lv=%0d mis=%0d to=%0d",
             name, stall_cnt, busy_cyc, c_addr, c_be, c_we, c_wdata, d_ld, d_lv, d_mis, d_to);
  endtask

  initial begin
    rst = 1'b0;
    me_alu_o = '0; me_regs_data2 = '0; me_rs2 = '0; me_mem_read = 1'b0; me_mem_write = 1'b0;
    me_func3_code = '0; wb_rd = '0; wb_regs_write = 1'b0; wb_data = '0;
    dbus_ack = 1'b0; dbus_rdata = '0;

    #12;
    check("rst_req", {31'd0, dbus_req}, 32'd0);
    check("rst_stall", {31'd0, mem_stall}, 32'd0);
    check("rst_load_data", load_data, 32'd0);
    check("rst_load_valid", {31'd0, load_valid}, 32'd0);
    check("rst_misalign", {31'd0, misalign_err}, 32'd0);
    check("rst_timeout", {31'd0, bus_timeout_err}, 32'd0);
    check("rst_be", {28'd0, dbus_be}, 32'd0);
    check("rst_addr", dbus_addr, 32'd0);
    rst = 1'b1;

    // LW 0x100, ack on 2nd request cycle
    issue(1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'd0, 5'd0);
    run_access("lw", 2, 32'hDEAD_BEEF);
    check("lw_addr", c_addr, 32'h0000_0100);
    check("lw_be", {28'd0, c_be}, 32'h0000_000F);
    check("lw_we", {31'd0, c_we}, 32'd0);
    check("lw_stall", stall_cnt, 32'd3);
    check("lw_data", d_ld, 32'hDEAD_BEEF);
    check("lw_valid", {31'd0, d_lv}, 32'd1);
    check("lw_valid_pulse", {31'd0, post_lv}, 32'd0);

    // LB / LBU at byte 3
    issue(1'b1, 1'b0, 3'b000, 32'h0000_0203, 32'd0, 5'd0);
    run_access("lb", 1, 32'h8012_3456);
    check("lb_addr", c_addr, 32'h0000_0200);
    check("lb_be", {28'd0, c_be}, 32'h0000_0008);
    check("lb_data", d_ld, 32'hFFFF_FF80);
    check("lb_stall", stall_cnt, 32'd2);
    issue(1'b1, 1'b0, 3'b100, 32'h0000_0203, 32'd0, 5'd0);
    run_access("lbu", 1, 32'h8012_3456);
    check("lbu_data", d_ld, 32'h0000_0080);

    // LH / LHU at upper half
    issue(1'b1, 1'b0, 3'b001, 32'h0000_0206, 32'd0, 5'd0);
    run_access("lh", 3, 32'h8001_7F7F);
    check("lh_be", {28'd0, c_be}, 32'h0000_000C);
    check("lh_data", d_ld, 32'hFFFF_8001);
    check("lh_stall", stall_cnt, 32'd4);
    issue(1'b1, 1'b0, 3'b101, 32'h0000_0206, 32'd0, 5'd0);
    run_access("lhu", 1, 32'h8001_7F7F);
    check("lhu_data", d_ld, 32'h0000_8001);

    // SH 0x12
    issue(1'b0, 1'b1, 3'b001, 32'h0000_0012, 32'h0000_ABCD, 5'd7);
    run_access("sh", 1, 32'd0);
    check("sh_we", {31'd0, c_we}, 32'd1);
    check("sh_be", {28'd0, c_be}, 32'h0000_000C);
    check("sh_addr", c_addr, 32'h0000_0010);
    check("sh_wdata", c_wdata, 32'hABCD_ABCD);
    check("sh_no_valid", {31'd0, d_lv}, 32'd0);

    // SB at byte 1
    issue(1'b0, 1'b1, 3'b000, 32'h0000_0021, 32'h1234_56A5, 5'd7);
    run_access("sb", 1, 32'd0);
    check("sb_be", {28'd0, c_be}, 32'h0000_0002);
    check("sb_wdata", c_wdata, 32'hA5A5_A5A5);

    // SW with forwarding from WB
    wb_rd = 5'd5; wb_regs_write = 1'b1; wb_data = 32'h1122_3344;
    issue(1'b0, 1'b1, 3'b010, 32'h0000_0040, 32'hCAFE_F00D, 5'd5);
    run_access("sw_fwd", 1, 32'd0);
    check("sw_fwd_wdata", c_wdata, 32'h1122_3344);
    check("sw_fwd_be", {28'd0, c_be}, 32'h0000_000F);

    // x0 is never forwarded
    wb_rd = 5'd0;
    issue(1'b0, 1'b1, 3'b010, 32'h0000_0044, 32'hCAFE_F00D, 5'd0);
    run_access("sw_x0", 1, 32'd0);
    check("sw_x0_wdata", c_wdata, 32'hCAFE_F00D);
    wb_regs_write = 1'b0;

    // Misaligned LW: no bus cycle
    issue(1'b1, 1'b0, 3'b010, 32'h0000_0102, 32'd0, 5'd0);
    run_access("lw_mis", 1, 32'd0);
    check("lw_mis_busy", busy_cyc, 32'd0);
    check("lw_mis_err", {31'd0, d_mis}, 32'd1);
    check("lw_mis_pulse", {31'd0, post_mis}, 32'd0);
    check("lw_mis_stall", stall_cnt, 32'd1);

    // Illegal func3 and SBU-style store
    issue(1'b1, 1'b0, 3'b011, 32'h0000_0100, 32'd0, 5'd0);
    run_access("f3_011", 1, 32'd0);
    check("f3_011_err", {31'd0, d_mis}, 32'd1);
    check("f3_011_busy", busy_cyc, 32'd0);
    issue(1'b0, 1'b1, 3'b100, 32'h0000_0100, 32'd0, 5'd0);
    run_access("store_bu", 1, 32'd0);
    check("store_bu_err", {31'd0, d_mis}, 32'd1);

    // No ack: timeout after 16 request cycles
    issue(1'b1, 1'b0, 3'b010, 32'h0000_0300, 32'd0, 5'd0);
    run_access("lw_to", 0, 32'd0);
    check("lw_to_busy", busy_cyc, 32'd16);
    check("lw_to_err", {31'd0, d_to}, 32'd1);
    check("lw_to_data", d_ld, 32'd0);
    check("lw_to_stall", stall_cnt, 32'd17);
    check("lw_to_pulse", {31'd0, post_to}, 32'd0);

    // Ack on the 16th request cycle still wins over the timeout
    issue(1'b1, 1'b0, 3'b010, 32'h0000_0304, 32'd0, 5'd0);
    run_access("lw_late", 16, 32'h0BAD_F00D);
    check("lw_late_to", {31'd0, d_to}, 32'd0);
    check("lw_late_data", d_ld, 32'h0BAD_F00D);

    // Async reset mid-BUSY
    issue(1'b1, 1'b0, 3'b010, 32'h0000_0500, 32'd0, 5'd0);
    repeat (3) @(posedge clk);
    #1;
    check("mid_rst_req_before", {31'd0, dbus_req}, 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check("mid_rst_req_drop", {31'd0, dbus_req}, 32'd0);
    me_mem_read = 1'b0;
    #1;
    check("mid_rst_idle", {31'd0, mem_stall}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    dbus_ack = 1'b1; dbus_rdata = 32'h5555_5555;
    @(posedge clk); #1;
    dbus_ack = 1'b0; dbus_rdata = '0;
    @(posedge clk); #1;
    check("late_ack_valid", {31'd0, load_valid}, 32'd0);
    check("late_ack_data", load_data, 32'd0);
    check("late_ack_req", {31'd0, dbus_req}, 32'd0);
    $display("txn mid_rst: req dropped on reset, late ack ignored");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
